// File: rtl/multi_debouncer_pkg.sv
// multi_debouncer_pkg: board-clock timing defaults and channel FSM encoding.
// Shared by multi_debouncer and debounce_ch (DEBOUNCE_REPEAT_EN adds repeat defaults).
package multi_debouncer_pkg;

    localparam int unsigned CNT_W_DEF         = 16;
    localparam int unsigned SYNC_STAGES_DEF   = 2;
    localparam int unsigned DB_COUNT_DEF      = 50000;
    localparam int unsigned RPT_W_DEF         = 16;
    localparam int unsigned REPEAT_DELAY_DEF  = 50000;
    localparam int unsigned REPEAT_PERIOD_DEF = 10000;

    localparam logic [0:0] ST_STABLE   = 1'b0;
    localparam logic [0:0] ST_COUNTING = 1'b1;

endpackage

// File: rtl/multi_debouncer_debounce_ch.sv
// debounce_ch: one channel - synchroniser, stability FSM/counter, edge strobes.
// With DEBOUNCE_REPEAT_EN defined, adds a hold-to-repeat pulse output rep_o.
module debounce_ch
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned DB_COUNT      = DB_COUNT_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned RPT_W         = RPT_W_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic sig_o,
    output logic rise_o,
    output logic fall_o
`ifdef DEBOUNCE_REPEAT_EN
    ,
    output logic rep_o
`endif
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_COUNT - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [0:0]             state_q;
    logic [0:0]             state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic [CNT_W-1:0]       cnt_cur;
    logic                   lvl_q;
    logic                   lvl_d;
    logic                   rise_q;
    logic                   rise_d;
    logic                   fall_q;
    logic                   fall_d;
    logic                   s;
    logic                   mismatch;
    logic                   commit;

    assign s        = sync_q[SYNC_STAGES-1];
    assign sync_d   = {sync_q[SYNC_STAGES-2:0], sig_i};
    assign mismatch = (s != lvl_q);

    // A channel in STABLE always restarts its count from zero.
    assign cnt_cur  = (state_q == ST_COUNTING) ? cnt_q : '0;
    assign commit   = mismatch && (cnt_cur == CNT_LAST);

    always_comb begin
        state_d = ST_STABLE;
        cnt_d   = '0;
        if (mismatch && !commit) begin
            state_d = ST_COUNTING;
            cnt_d   = cnt_cur + CNT_W'(1);
        end
    end

    always_comb begin
        lvl_d  = lvl_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (commit) begin
            lvl_d  = s;
            rise_d = s;
            fall_d = ~s;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            state_q <= ST_STABLE;
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lvl_q   <= lvl_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sig_o  = lvl_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY);
    localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD);

    logic [RPT_W-1:0] hold_q;
    logic [RPT_W-1:0] hold_d;
    logic [RPT_W-1:0] hold_inc;
    logic [RPT_W-1:0] hold_tgt;
    logic             armed_q;
    logic             armed_d;
    logic             rep_q;
    logic             rep_d;

    assign hold_inc = hold_q + RPT_W'(1);
    assign hold_tgt = armed_q ? RPT_NEXT : RPT_FIRST;

    // Counter first runs to the initial delay, then re-arms on the period.
    always_comb begin
        hold_d  = hold_q;
        armed_d = armed_q;
        rep_d   = 1'b0;
        if (commit) begin
            hold_d  = '0;
            armed_d = 1'b0;
        end else if (lvl_q) begin
            if (hold_inc == hold_tgt) begin
                rep_d   = 1'b1;
                hold_d  = '0;
                armed_d = 1'b1;
            end else begin
                hold_d  = hold_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q  <= '0;
            armed_q <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            armed_q <= armed_d;
            rep_q   <= rep_d;
        end
    end

    assign rep_o = rep_q;
`endif

endmodule

// File: rtl/multi_debouncer.sv
// multi_debouncer: N_CH independent debounce_ch instances with level and edge strobes.
// Defining DEBOUNCE_REPEAT_EN adds hold-to-repeat parameters and the rep_o output.
module multi_debouncer
    import multi_debouncer_pkg::*;
#(
    parameter int unsigned N_CH          = 4,
    parameter int unsigned CNT_W         = CNT_W_DEF,
    parameter int unsigned DB_COUNT      = DB_COUNT_DEF,
    parameter int unsigned SYNC_STAGES   = SYNC_STAGES_DEF
`ifdef DEBOUNCE_REPEAT_EN
    ,
    parameter int unsigned RPT_W         = RPT_W_DEF,
    parameter int unsigned REPEAT_DELAY  = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] sig_i,
    output logic [N_CH-1:0] sig_o,
    output logic [N_CH-1:0] rise_o,
    output logic [N_CH-1:0] fall_o
`ifdef DEBOUNCE_REPEAT_EN
    ,
    output logic [N_CH-1:0] rep_o
`endif
);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_ch #(
            .CNT_W        (CNT_W),
            .DB_COUNT     (DB_COUNT),
            .SYNC_STAGES  (SYNC_STAGES)
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .RPT_W        (RPT_W),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .sig_i (sig_i[i]),
            .sig_o (sig_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i])
`ifdef DEBOUNCE_REPEAT_EN
            ,
            .rep_o (rep_o[i])
`endif
        );
    end

endmodule
